// File: rtl/soc_run_ctrl.sv
// -----------------------------------------------------------------------------
// soc_run_ctrl
//
// Run-control sequencer for the min-SOPC. Produces the core reset, the
// per-channel halt request vector, single-step windows and a run-cycle
// watchdog that ends a simulation or bring-up run.
//
// Ports:
//   clk       in   system clock, everything on the rising edge
//   rst       in   synchronous active-high reset, highest priority
//   soft_rst  in   synchronous restart pulse from debug (beats all but rst)
//   halt_cmd  in   global halt request (level)
//   step_req  in   single-step pulse, only honoured in HALT
//   halt_ext  in   per-channel halt request forwarded while running
//   core_rst  out  registered reset to the SOPC
//   halt_req  out  registered halt vector to the SOPC
//   run_cnt   out  number of cycles spent in RUN or STEP
//   done      out  sticky watchdog timeout flag
//   state_o   out  encoded state: RST=0, RUN=1, HALT=2, STEP=3, DONE=4
//
// Handshake note: there is no valid/ready traffic here. All inputs are plain
// levels or single-cycle pulses sampled on the rising edge; all outputs are
// registers, so every output reflects the state entered on the last edge.
// -----------------------------------------------------------------------------
module soc_run_ctrl #(
  parameter int HALT_W     = 2,
  parameter int RST_HOLD   = 97,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 5000,
  parameter int STEP_LEN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              halt_cmd,
  input  logic              step_req,
  input  logic [HALT_W-1:0] halt_ext,
  output logic              core_rst,
  output logic [HALT_W-1:0] halt_req,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              done,
  output logic [2:0]        state_o
);

  // Zero-length hold / step windows behave as a single cycle.
  localparam int LP_HOLD   = (RST_HOLD < 1) ? 1 : RST_HOLD;
  localparam int LP_STEP   = (STEP_LEN < 1) ? 1 : STEP_LEN;
  localparam int LP_HOLD_W = (LP_HOLD > 1) ? $clog2(LP_HOLD) : 1;
  localparam int LP_STEP_W = (LP_STEP > 1) ? $clog2(LP_STEP) : 1;

  localparam logic [LP_HOLD_W-1:0] LP_HOLD_LAST = LP_HOLD_W'(LP_HOLD - 1);
  localparam logic [LP_HOLD_W-1:0] LP_HOLD_ONE  = LP_HOLD_W'(1);
  localparam logic [LP_STEP_W-1:0] LP_STEP_LAST = LP_STEP_W'(LP_STEP - 1);
  localparam logic [LP_STEP_W-1:0] LP_STEP_ONE  = LP_STEP_W'(1);
  localparam logic [CNT_W-1:0]     LP_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     LP_CNT_LAST  =
    CNT_W'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);
  localparam bit                   LP_WDOG_EN   = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_RUN  = 3'd1,
    ST_HALT = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [LP_HOLD_W-1:0]  r_hold_cnt;
  logic [LP_STEP_W-1:0]  r_step_cnt;
  logic [CNT_W-1:0]      r_run_cnt;
  logic                  r_done;
  logic                  r_core_rst;
  logic [HALT_W-1:0]     r_halt_req;

  state_t                w_state_nxt;
  logic [LP_HOLD_W-1:0]  w_hold_nxt;
  logic [LP_STEP_W-1:0]  w_step_nxt;
  logic [CNT_W-1:0]      w_run_cnt_nxt;
  logic                  w_done_nxt;
  logic                  w_core_rst_nxt;
  logic [HALT_W-1:0]     w_halt_req_nxt;
  logic                  w_cnt_inc;
  logic                  w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RST;
      r_hold_cnt <= '0;
      r_step_cnt <= '0;
      r_run_cnt  <= '0;
      r_done     <= 1'b0;
      r_core_rst <= 1'b1;
      r_halt_req <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_step_cnt <= w_step_nxt;
      r_run_cnt  <= w_run_cnt_nxt;
      r_done     <= w_done_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_halt_req <= w_halt_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold_cnt;
    w_step_nxt     = r_step_cnt;
    w_run_cnt_nxt  = r_run_cnt;
    w_cnt_inc      = 1'b0;
    w_timeout      = 1'b0;
    w_done_nxt     = 1'b0;
    w_core_rst_nxt = 1'b0;
    w_halt_req_nxt = '0;

    case (r_state)
      ST_RST: begin
        if (r_hold_cnt == LP_HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + LP_HOLD_ONE;
        end
      end
      ST_RUN: begin
        w_cnt_inc = 1'b1;
        if (halt_cmd) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // A step request wins over a simultaneous halt_cmd release.
        if (step_req) begin
          w_state_nxt = ST_STEP;
          w_step_nxt  = '0;
        end else if (!halt_cmd) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        // step_req is not looked at here: steps are never queued.
        w_cnt_inc = 1'b1;
        if (r_step_cnt == LP_STEP_LAST) begin
          w_state_nxt = halt_cmd ? ST_HALT : ST_RUN;
        end else begin
          w_step_nxt = r_step_cnt + LP_STEP_ONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_RST;
      end
    endcase

    if (w_cnt_inc) begin
      w_run_cnt_nxt = r_run_cnt + LP_CNT_ONE;
    end

    // The watchdog overrides whatever transition RUN/STEP picked above.
    w_timeout = LP_WDOG_EN && w_cnt_inc && (r_run_cnt == LP_CNT_LAST);
    if (w_timeout) begin
      w_state_nxt = ST_DONE;
    end

    if (soft_rst) begin
      w_state_nxt   = ST_RST;
      w_hold_nxt    = '0;
      w_step_nxt    = '0;
      w_run_cnt_nxt = '0;
    end

    // Outputs are registered views of the state being entered.
    w_core_rst_nxt = (w_state_nxt == ST_RST);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    case (w_state_nxt)
      ST_RUN:           w_halt_req_nxt = halt_ext;
      ST_HALT, ST_DONE: w_halt_req_nxt = {HALT_W{1'b1}};
      default:          w_halt_req_nxt = '0;
    endcase
  end

  assign core_rst = r_core_rst;
  assign halt_req = r_halt_req;
  assign run_cnt  = r_run_cnt;
  assign done     = r_done;
  assign state_o  = r_state;

endmodule
